// File: rtl/iec_sd_pkg.sv
// Shared types and widths for the IEC drive SD-channel arbitration logic.
package iec_sd_pkg;

  localparam int IEC_SD_MAX_DRIVES = 4;
  localparam int LBA_W             = 32;
  localparam int BLK_CNT_W         = 6;
  localparam int DRV_IDX_W         = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } sd_arb_state_t;

endpackage

// File: rtl/iec_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last',
// scanning last+1, last+2, ... modulo NUM_DRIVES.
module iec_rr_pick
  import iec_sd_pkg::*;
#(
  parameter int NUM_DRIVES = IEC_SD_MAX_DRIVES
) (
  input  logic [NUM_DRIVES-1:0] eligible,
  input  logic [DRV_IDX_W-1:0]  last,
  output logic                  valid,
  output logic [DRV_IDX_W-1:0]  winner
);

  // Walk the rotation order once; the first hit freezes valid/winner.
  always_comb begin
    int   idx_s;
    logic hit_s;
    valid  = 1'b0;
    winner = '0;
    idx_s  = 0;
    hit_s  = 1'b0;
    for (int k = 1; k <= NUM_DRIVES; k++) begin
      idx_s = (int'(last) + k) % NUM_DRIVES;
      for (int j = 0; j < NUM_DRIVES; j++) begin
        hit_s  = !valid && eligible[j] && (j == idx_s);
        winner = hit_s ? DRV_IDX_W'(j) : winner;
        valid  = valid | hit_s;
      end
    end
  end

endmodule

// File: rtl/iec_sd_arbiter.sv
// Round-robin arbiter sharing one host SD block channel between up to four
// IEC drive track loaders. Requests are latched on grant so a withdrawn or
// disabled request still completes against the drive that was granted.
module iec_sd_arbiter
  import iec_sd_pkg::*;
#(
  parameter int NUM_DRIVES = IEC_SD_MAX_DRIVES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_DRIVES-1:0]           drv_en,
  input  logic [NUM_DRIVES*LBA_W-1:0]     req_lba,
  input  logic [NUM_DRIVES*BLK_CNT_W-1:0] req_blk_cnt,
  input  logic [NUM_DRIVES-1:0]           req_rd,
  input  logic [NUM_DRIVES-1:0]           req_wr,
  output logic [NUM_DRIVES-1:0]           req_ack,
  input  logic [NUM_DRIVES*8-1:0]         req_buff_din,
  output logic [LBA_W-1:0]                sd_lba,
  output logic [BLK_CNT_W-1:0]            sd_blk_cnt,
  output logic                            sd_rd,
  output logic                            sd_wr,
  input  logic                            sd_ack,
  output logic [7:0]                      sd_buff_din,
  output logic [DRV_IDX_W-1:0]            sd_drive,
  output logic                            busy
);

  sd_arb_state_t         state_r, state_nxt_s;
  logic [DRV_IDX_W-1:0]  last_r, last_nxt_s;
  logic [NUM_DRIVES-1:0] eligible_s;
  logic                  pick_valid_s;
  logic [DRV_IDX_W-1:0]  pick_idx_s;
  logic [LBA_W-1:0]      win_lba_s, lba_nxt_s;
  logic [BLK_CNT_W-1:0]  win_blk_s, blk_nxt_s;
  logic                  win_wr_s, rd_nxt_s, wr_nxt_s;
  logic [DRV_IDX_W-1:0]  drive_nxt_s;
  logic                  ack_gate_s;

  assign eligible_s = drv_en & (req_rd | req_wr);

  iec_rr_pick #(.NUM_DRIVES(NUM_DRIVES)) u_pick (
    .eligible (eligible_s),
    .last     (last_r),
    .valid    (pick_valid_s),
    .winner   (pick_idx_s)
  );

  // Select the winning drive's request fields.
  always_comb begin
    logic sel_s;
    win_lba_s = '0;
    win_blk_s = '0;
    win_wr_s  = 1'b0;
    sel_s     = 1'b0;
    for (int j = 0; j < NUM_DRIVES; j++) begin
      sel_s     = (pick_idx_s == DRV_IDX_W'(j));
      win_lba_s = sel_s ? req_lba[j*LBA_W +: LBA_W] : win_lba_s;
      win_blk_s = sel_s ? req_blk_cnt[j*BLK_CNT_W +: BLK_CNT_W] : win_blk_s;
      win_wr_s  = sel_s ? req_wr[j] : win_wr_s;
    end
  end

  // Next-state and next registered-output logic.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    lba_nxt_s   = sd_lba;
    blk_nxt_s   = sd_blk_cnt;
    drive_nxt_s = sd_drive;
    rd_nxt_s    = sd_rd;
    wr_nxt_s    = sd_wr;
    case (state_r)
      IDLE: begin
        // A still-high host ack means a stale transfer; wait it out.
        if (pick_valid_s && !sd_ack) begin
          state_nxt_s = GRANT;
          lba_nxt_s   = win_lba_s;
          blk_nxt_s   = win_blk_s;
          drive_nxt_s = pick_idx_s;
          wr_nxt_s    = win_wr_s;
          rd_nxt_s    = !win_wr_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (sd_ack) begin
          state_nxt_s = XFER;
          rd_nxt_s    = 1'b0;
          wr_nxt_s    = 1'b0;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = XFER;
        end
      end
      RELEASE: begin
        state_nxt_s = IDLE;
        last_nxt_s  = sd_drive;
      end
      default: begin
        state_nxt_s = IDLE;
        rd_nxt_s    = 1'b0;
        wr_nxt_s    = 1'b0;
      end
    endcase
  end

  // State and registered host-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      last_r     <= DRV_IDX_W'(NUM_DRIVES - 1);
      sd_lba     <= '0;
      sd_blk_cnt <= '0;
      sd_drive   <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      sd_lba     <= lba_nxt_s;
      sd_blk_cnt <= blk_nxt_s;
      sd_drive   <= drive_nxt_s;
      sd_rd      <= rd_nxt_s;
      sd_wr      <= wr_nxt_s;
      busy       <= (state_nxt_s != IDLE);
    end
  end

  // Route host ack and write data to/from the granted drive only.
  always_comb begin
    logic hit_s;
    ack_gate_s  = ((state_r == GRANT) || (state_r == XFER)) && sd_ack;
    req_ack     = '0;
    sd_buff_din = '0;
    hit_s       = 1'b0;
    for (int j = 0; j < NUM_DRIVES; j++) begin
      hit_s       = (sd_drive == DRV_IDX_W'(j));
      req_ack[j]  = ack_gate_s && hit_s;
      sd_buff_din = hit_s ? req_buff_din[j*8 +: 8] : sd_buff_din;
    end
  end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// Self-checking bench for iec_sd_arbiter: table of single-drive transactions,
// plus contention, enable-mask and reset-during-transfer sequences.
module tb_iec_sd_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   drv_en;
  logic [N*32-1:0] req_lba;
  logic [N*6-1:0] req_blk_cnt;
  logic [N-1:0]   req_rd, req_wr, req_ack;
  logic [N*8-1:0] req_buff_din;
  logic [31:0]    sd_lba;
  logic [5:0]     sd_blk_cnt;
  logic           sd_rd, sd_wr, sd_ack, busy;
  logic [7:0]     sd_buff_din;
  logic [1:0]     sd_drive;

  typedef struct {
    int          drv;
    logic        wr;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic [7:0]  din;
  } exp_t;

  typedef struct {
    int          drv;
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic [5:0]  blk;
    logic [7:0]  din;
    int          ack_delay;
    int          ack_len;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  iec_sd_arbiter #(.NUM_DRIVES(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .drv_en       (drv_en),
    .req_lba      (req_lba),
    .req_blk_cnt  (req_blk_cnt),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_din (req_buff_din),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_din  (sd_buff_din),
    .sd_drive     (sd_drive),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int d, input logic wr);
    exp_t e;
    e.drv = d;
    e.wr  = wr;
    e.lba = req_lba[d*32 +: 32];
    e.blk = req_blk_cnt[d*6 +: 6];
    e.din = req_buff_din[d*8 +: 8];
    return e;
  endfunction

  // Host model: wait for a strobe, compare against the scoreboard head, then
  // run the ack handshake. The drive drops its request when it sees its ack.
  task automatic do_txn(input int ack_delay, input int ack_len, input int max_wait,
                        output int w, output int d);
    exp_t e;
    logic [3:0] oh;
    w = 0;
    d = -1;
    while (!(sd_rd || sd_wr) && (w < max_wait)) begin
      tick();
      w++;
    end
    if (!(sd_rd || sd_wr) || (sb.size() == 0)) begin
      n_vec++;
      n_miss++;
      $display("FAIL grant: strobe=%0b queued=%0d after %0d cycles", sd_rd | sd_wr, sb.size(), w);
      return;
    end
    e  = sb.pop_front();
    d  = e.drv;
    oh = 4'b0001 << d;
    chk("sd_drive", sd_drive, e.drv);
    chk("sd_lba", sd_lba, e.lba);
    chk("sd_blk_cnt", sd_blk_cnt, e.blk);
    chk("sd_wr", sd_wr, e.wr);
    chk("sd_rd", sd_rd, !e.wr);
    chk("sd_buff_din", sd_buff_din, e.din);
    chk("busy_grant", busy, 1);
    repeat (ack_delay) tick();
    chk("strobe_hold", sd_rd | sd_wr, 1);
    chk("ack_pre", req_ack, 0);
    sd_ack = 1'b1;
    #1;
    chk("ack_route", req_ack, oh);
    req_rd[d] = 1'b0;
    req_wr[d] = 1'b0;
    for (int i = 0; i < ack_len; i++) begin
      tick();
      chk("strobe_clr", {sd_rd, sd_wr}, 0);
      chk("ack_hold", req_ack, oh);
      chk("buff_din_xfer", sd_buff_din, e.din);
    end
    sd_ack = 1'b0;
    #1;
    chk("ack_off", req_ack, 0);
    tick();
    tick();
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    vec_t vt[4];
    int   w, d;

    vt[0] = '{drv:1, rd:1'b1, wr:1'b0, lba:32'h0000_0123, blk:6'd5,  din:8'h11, ack_delay:4, ack_len:20};
    vt[1] = '{drv:3, rd:1'b0, wr:1'b1, lba:32'hDEAD_BEEF, blk:6'd63, din:8'hA5, ack_delay:2, ack_len:4};
    vt[2] = '{drv:0, rd:1'b1, wr:1'b1, lba:32'h0000_0000, blk:6'd0,  din:8'h3C, ack_delay:1, ack_len:2};
    vt[3] = '{drv:2, rd:1'b1, wr:1'b0, lba:32'hFFFF_FFFF, blk:6'd1,  din:8'h7E, ack_delay:0, ack_len:1};

    reset        = 1'b1;
    drv_en       = 4'b1111;
    req_lba      = '0;
    req_blk_cnt  = '0;
    req_rd       = '0;
    req_wr       = '0;
    req_buff_din = '0;
    sd_ack       = 1'b0;
    tick();
    tick();
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_sd_blk_cnt", sd_blk_cnt, 0);
    chk("rst_strobes", {sd_rd, sd_wr}, 0);
    chk("rst_sd_drive", sd_drive, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ack", req_ack, 0);
    reset = 1'b0;

    // Table of single-drive transactions.
    for (int i = 0; i < 4; i++) begin
      req_buff_din = '0;
      req_buff_din[vt[i].drv*8 +: 8] = vt[i].din;
      req_lba[vt[i].drv*32 +: 32]    = vt[i].lba;
      req_blk_cnt[vt[i].drv*6 +: 6]  = vt[i].blk;
      req_rd[vt[i].drv] = vt[i].rd;
      req_wr[vt[i].drv] = vt[i].wr;
      sb.push_back(mk(vt[i].drv, vt[i].wr));
      do_txn(vt[i].ack_delay, vt[i].ack_len, 8, w, d);
      chk("latency", w, 1);
      chk("idle_busy", busy, 0);
    end

    // Contention: drives 0, 2, 3 re-request right after each transfer.
    reset  = 1'b1;
    req_rd = '0;
    req_wr = '0;
    tick();
    reset = 1'b0;
    sb.delete();
    req_buff_din = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < N; i++) begin
      req_lba[i*32 +: 32] = 32'h1000 + i;
      req_blk_cnt[i*6 +: 6] = 6'(i + 8);
    end
    req_rd = 4'b1101;
    sb.push_back(mk(0, 1'b0));
    sb.push_back(mk(2, 1'b0));
    sb.push_back(mk(3, 1'b0));
    for (int k = 0; k < 6; k++) begin
      do_txn(1, 2, 4, w, d);
      chk("rr_latency", w, 1);
      if (d >= 0) begin
        req_rd[d] = 1'b1;
        sb.push_back(mk(d, 1'b0));
      end
    end
    req_rd = '0;
    sb.delete();
    tick();

    // Enable mask blocks drive 0 until its enable is set.
    drv_en = 4'b1110;
    req_lba[0 +: 32] = 32'h0000_0E0E;
    req_blk_cnt[0 +: 6] = 6'd3;
    req_rd[0] = 1'b1;
    repeat (3) begin
      tick();
      chk("mask_no_rd", sd_rd, 0);
      chk("mask_busy", busy, 0);
    end
    drv_en = 4'b1111;
    sb.push_back(mk(0, 1'b0));
    do_txn(0, 3, 4, w, d);
    chk("mask_latency", w, 1);

    // Reset in the middle of a transfer with the host ack stuck high.
    req_lba[32 +: 32] = 32'h0000_AAAA;
    req_rd[1] = 1'b1;
    tick();
    chk("mid_sd_rd", sd_rd, 1);
    chk("mid_sd_drive", sd_drive, 1);
    sd_ack = 1'b1;
    #1;
    chk("mid_ack", req_ack, 4'b0010);
    req_rd[1] = 1'b0;
    tick();
    tick();
    chk("mid_ack_xfer", req_ack, 4'b0010);
    req_lba[64 +: 32]  = 32'h0000_2222;
    req_blk_cnt[12 +: 6] = 6'd2;
    req_rd[2] = 1'b1;
    reset = 1'b1;
    tick();
    chk("rst_mid_ack", req_ack, 0);
    chk("rst_mid_rd", sd_rd, 0);
    chk("rst_mid_busy", busy, 0);
    reset = 1'b0;
    repeat (5) begin
      tick();
      chk("stale_no_rd", sd_rd, 0);
      chk("stale_no_ack", req_ack, 0);
    end
    sd_ack = 1'b0;
    sb.delete();
    sb.push_back(mk(2, 1'b0));
    do_txn(1, 1, 4, w, d);
    chk("post_stale_latency", w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
